hazard_control_unit: RTL and testbench

Pipeline sequencing controller for the 16-bit five-stage CPU. It sits beside the datapath and drives the fetch-stage `if_pc_stop` / `if_pc_mux` controls, the IF/ID hold and flush, and the bubble inserts into ID/EX and EX/MEM. It resolves four hazard sources in fixed priority: taken branch, multi-cycle multiply/divide, load-use, and halt. It also keeps a saturating stall-cycle counter for performance checks.

---
 rtl/hazard_control_unit.sv | 124 ++++++++++++
 tb/tb_hazard_control_unit.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_control_unit.sv
// Pipeline sequencing controller: resolves taken-branch, mul/div, load-use and
// halt hazards in fixed priority and keeps a saturating stall-cycle counter.
module hazard_control_unit #(
  parameter int REG_ADDR_W    = 4,
  parameter int MULDIV_CYCLES = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_uses_rs1,
  input  logic                  id_uses_rs2,
  input  logic                  id_halt,
  input  logic                  ex_mem_read,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_muldiv,
  input  logic                  ex_branch_taken,
  output logic                  if_pc_stop,
  output logic                  if_pc_mux,
  output logic                  if_id_hold,
  output logic                  if_id_flush,
  output logic                  id_ex_bubble,
  output logic                  ex_hold,
  output logic                  ex_mem_bubble,
  output logic                  halted,
  output logic [15:0]           stall_cycles
);

  localparam int CNT_W = (MULDIV_CYCLES > 2) ? $clog2(MULDIV_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MULDIV_CYCLES - 2);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    MULDIV = 2'd1,
    HALT   = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             halted_q;
  logic [15:0]      stall_q;
  logic             load_use;

  assign load_use = ex_mem_read &&
                    ((id_uses_rs1 && (id_rs1 == ex_rd)) ||
                     (id_uses_rs2 && (id_rs2 == ex_rd)));

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    if_pc_stop    = 1'b0;
    if_pc_mux     = 1'b0;
    if_id_hold    = 1'b0;
    if_id_flush   = 1'b0;
    id_ex_bubble  = 1'b0;
    ex_hold       = 1'b0;
    ex_mem_bubble = 1'b0;
    if (!reset) begin
      case (state_q)
        RUN: begin
          if (ex_branch_taken) begin
            if_pc_mux    = 1'b1;
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
          end else if (ex_muldiv) begin
            if_pc_stop    = 1'b1;
            if_id_hold    = 1'b1;
            ex_hold       = 1'b1;
            ex_mem_bubble = 1'b1;
            state_d       = MULDIV;
            cnt_d         = CNT_LOAD;
          end else if (load_use) begin
            if_pc_stop   = 1'b1;
            if_id_hold   = 1'b1;
            id_ex_bubble = 1'b1;
          end else if (id_halt) begin
            if_pc_stop   = 1'b1;
            if_id_hold   = 1'b1;
            id_ex_bubble = 1'b1;
            state_d      = HALT;
          end
        end
        MULDIV: begin
          // cnt==0 is the cycle the mul/div result leaves EX, so nothing stalls
          if (cnt_q != '0) begin
            if_pc_stop    = 1'b1;
            if_id_hold    = 1'b1;
            ex_hold       = 1'b1;
            ex_mem_bubble = 1'b1;
            cnt_d         = cnt_q - CNT_W'(1);
          end else begin
            state_d = RUN;
          end
        end
        HALT: begin
          if_pc_stop   = 1'b1;
          if_id_hold   = 1'b1;
          id_ex_bubble = 1'b1;
        end
        default: state_d = RUN;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= RUN;
      cnt_q    <= '0;
      halted_q <= 1'b0;
      stall_q  <= 16'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      halted_q <= (state_d == HALT);
      // HALT cycles are not stalls; only the halt-detect cycle counts
      if (if_pc_stop && (state_q != HALT) && (stall_q != 16'hFFFF))
        stall_q <= stall_q + 16'd1;
    end
  end

  assign halted       = halted_q && !reset;
  assign stall_cycles = reset ? 16'd0 : stall_q;

endmodule

// File: tb/tb_hazard_control_unit.sv
// Self-checking bench for hazard_control_unit: a cycle-level behavioural model
// checked every cycle, plus directed scenarios pinned with literal expectations.
module tb_hazard_control_unit;

  localparam int AW  = 4;
  localparam int MDC = 4;

  logic          clock;
  logic          reset;
  logic [AW-1:0] id_rs1, id_rs2, ex_rd;
  logic          id_uses_rs1, id_uses_rs2, id_halt;
  logic          ex_mem_read, ex_muldiv, ex_branch_taken;
  logic          if_pc_stop, if_pc_mux, if_id_hold, if_id_flush;
  logic          id_ex_bubble, ex_hold, ex_mem_bubble, halted;
  logic [15:0]   stall_cycles;

  int vectors     = 0;
  int miscompares = 0;

  hazard_control_unit #(.REG_ADDR_W(AW), .MULDIV_CYCLES(MDC)) dut (
    .clock          (clock),
    .reset          (reset),
    .id_rs1         (id_rs1),
    .id_rs2         (id_rs2),
    .id_uses_rs1    (id_uses_rs1),
    .id_uses_rs2    (id_uses_rs2),
    .id_halt        (id_halt),
    .ex_mem_read    (ex_mem_read),
    .ex_rd          (ex_rd),
    .ex_muldiv      (ex_muldiv),
    .ex_branch_taken(ex_branch_taken),
    .if_pc_stop     (if_pc_stop),
    .if_pc_mux      (if_pc_mux),
    .if_id_hold     (if_id_hold),
    .if_id_flush    (if_id_flush),
    .id_ex_bubble   (id_ex_bubble),
    .ex_hold        (ex_hold),
    .ex_mem_bubble  (ex_mem_bubble),
    .halted         (halted),
    .stall_cycles   (stall_cycles)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_output(input string name, input logic [15:0] act, input logic [15:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic set_idle();
    id_rs1 = '0; id_rs2 = '0; ex_rd = '0;
    id_uses_rs1 = 0; id_uses_rs2 = 0; id_halt = 0;
    ex_mem_read = 0; ex_muldiv = 0; ex_branch_taken = 0;
  endtask

  task automatic apply_stimulus();
    id_rs1          = AW'($urandom_range(0, 3));
    id_rs2          = AW'($urandom_range(0, 3));
    ex_rd           = AW'($urandom_range(0, 3));
    id_uses_rs1     = ($urandom_range(0, 9) < 7);
    id_uses_rs2     = ($urandom_range(0, 9) < 5);
    ex_mem_read     = ($urandom_range(0, 9) < 5);
    ex_muldiv       = ($urandom_range(0, 99) < 15);
    ex_branch_taken = ($urandom_range(0, 99) < 15);
    id_halt         = ($urandom_range(0, 99) < 3);
  endtask

  // Model: md_pos is how many cycles the current mul/div has spent in EX
  // (0 = none in flight); m_halted marks the halted core.
  int md_pos   = 0;
  bit m_halted = 0;
  int m_stall  = 0;

  always @(negedge clock) begin
    bit lu;
    bit e_stop, e_mux, e_hold, e_flush, e_bub, e_exh, e_memb, e_halted;
    int e_stall;
    lu = ex_mem_read && ((id_uses_rs1 && id_rs1 == ex_rd) || (id_uses_rs2 && id_rs2 == ex_rd));
    {e_stop, e_mux, e_hold, e_flush, e_bub, e_exh, e_memb, e_halted} = '0;
    e_stall = 0;
    if (!reset) begin
      e_halted = m_halted;
      e_stall  = m_stall;
      if (m_halted) begin
        e_stop = 1; e_hold = 1; e_bub = 1;
      end else if (md_pos != 0) begin
        if (md_pos < MDC) begin e_stop = 1; e_hold = 1; e_exh = 1; e_memb = 1; end
      end else if (ex_branch_taken) begin
        e_mux = 1; e_flush = 1; e_bub = 1;
      end else if (ex_muldiv) begin
        e_stop = 1; e_hold = 1; e_exh = 1; e_memb = 1;
      end else if (lu || id_halt) begin
        e_stop = 1; e_hold = 1; e_bub = 1;
      end
    end
    check_output("if_pc_stop",    16'(if_pc_stop),    16'(e_stop));
    check_output("if_pc_mux",     16'(if_pc_mux),     16'(e_mux));
    check_output("if_id_hold",    16'(if_id_hold),    16'(e_hold));
    check_output("if_id_flush",   16'(if_id_flush),   16'(e_flush));
    check_output("id_ex_bubble",  16'(id_ex_bubble),  16'(e_bub));
    check_output("ex_hold",       16'(ex_hold),       16'(e_exh));
    check_output("ex_mem_bubble", 16'(ex_mem_bubble), 16'(e_memb));
    check_output("halted",        16'(halted),        16'(e_halted));
    check_output("stall_cycles",  stall_cycles,       16'(e_stall));
    // advance the model to the state after the coming rising edge
    if (reset) begin
      md_pos = 0; m_halted = 0; m_stall = 0;
    end else begin
      if (e_stop && !m_halted && m_stall < 65535) m_stall++;
      if (m_halted) begin
      end else if (md_pos != 0) begin
        md_pos = (md_pos >= MDC) ? 0 : md_pos + 1;
      end else if (ex_branch_taken) begin
      end else if (ex_muldiv) begin
        md_pos = 2;
      end else if (!lu && id_halt) begin
        m_halted = 1;
      end
    end
  end

  initial begin
    reset = 1;
    set_idle();
    repeat (3) begin apply_stimulus(); @(posedge clock); #1; end
    reset = 0;
    set_idle();
    @(negedge clock);
    check_output("reset_stall", stall_cycles, 16'd0);
    check_output("reset_halted", 16'(halted), 16'd0);

    // load-use on rs1
    @(posedge clock); #1;
    ex_mem_read = 1; ex_rd = 4'd3; id_rs1 = 4'd3; id_uses_rs1 = 1;
    @(negedge clock);
    check_output("lu_stop", 16'(if_pc_stop), 16'd1);
    check_output("lu_bubble", 16'(id_ex_bubble), 16'd1);
    check_output("lu_stall_before", stall_cycles, 16'd0);
    @(posedge clock); #1;
    set_idle();
    @(negedge clock);
    check_output("lu_stall_after", stall_cycles, 16'd1);
    // same registers but rs1 unused: no hazard
    @(posedge clock); #1;
    ex_mem_read = 1; ex_rd = 4'd3; id_rs1 = 4'd3; id_uses_rs1 = 0;
    @(negedge clock);
    check_output("lu_unused_stop", 16'(if_pc_stop), 16'd0);
    @(posedge clock); #1;
    set_idle();

    // mul/div held: three stall cycles, released on the fourth
    ex_muldiv = 1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      check_output("md_ex_hold", 16'(ex_hold), (i < 3) ? 16'd1 : 16'd0);
      check_output("md_mem_bubble", 16'(ex_mem_bubble), (i < 3) ? 16'd1 : 16'd0);
      @(posedge clock); #1;
    end
    set_idle();
    @(negedge clock);
    check_output("md_stall", stall_cycles, 16'd4);

    // branch beats load-use and halt together
    @(posedge clock); #1;
    ex_branch_taken = 1; ex_mem_read = 1; ex_rd = 4'd5; id_rs2 = 4'd5; id_uses_rs2 = 1; id_halt = 1;
    @(negedge clock);
    check_output("br_mux", 16'(if_pc_mux), 16'd1);
    check_output("br_flush", 16'(if_id_flush), 16'd1);
    check_output("br_stop", 16'(if_pc_stop), 16'd0);
    @(posedge clock); #1;
    set_idle();
    @(negedge clock);
    check_output("br_halted", 16'(halted), 16'd0);
    check_output("br_stall", stall_cycles, 16'd4);

    // randomized traffic with occasional resets
    for (int n = 0; n < 3000; n++) begin
      @(posedge clock); #1;
      apply_stimulus();
      reset = ($urandom_range(0, 99) < 2);
    end

    // reset in the middle of a mul/div
    @(posedge clock); #1;
    reset = 1; set_idle();
    @(posedge clock); #1;
    reset = 0; ex_muldiv = 1;
    @(posedge clock); #1;
    ex_muldiv = 0;
    @(posedge clock); #1;
    reset = 1;
    @(negedge clock);
    check_output("rst_md_stop", 16'(if_pc_stop), 16'd0);
    @(posedge clock); #1;
    reset = 0;
    @(negedge clock);
    check_output("rst_md_stall", stall_cycles, 16'd0);
    check_output("rst_md_ex_hold", 16'(ex_hold), 16'd0);
    @(posedge clock); #1;
    ex_muldiv = 1;
    @(posedge clock); #1;
    ex_muldiv = 0;
    @(posedge clock); #1;
    @(posedge clock); #1;
    @(negedge clock);
    check_output("fresh_md_release", 16'(ex_hold), 16'd0);
    check_output("fresh_md_stall", stall_cycles, 16'd3);

    // halt, then ignored branch pulses
    @(posedge clock); #1;
    id_halt = 1;
    @(negedge clock);
    check_output("halt_stop", 16'(if_pc_stop), 16'd1);
    check_output("halt_not_yet", 16'(halted), 16'd0);
    @(posedge clock); #1;
    id_halt = 0; ex_branch_taken = 1;
    @(negedge clock);
    check_output("halt_set", 16'(halted), 16'd1);
    check_output("halt_br_mux", 16'(if_pc_mux), 16'd0);
    check_output("halt_stall", stall_cycles, 16'd4);
    repeat (5) begin @(posedge clock); #1; end
    @(negedge clock);
    check_output("halt_stall_frozen", stall_cycles, 16'd4);

    // saturation: continuous load-use stalls
    @(posedge clock); #1;
    set_idle(); reset = 1;
    @(posedge clock); #1;
    reset = 0;
    ex_mem_read = 1; ex_rd = 4'd0; id_rs1 = 4'd0; id_uses_rs1 = 1;
    repeat (65540) begin @(posedge clock); #1; end
    @(negedge clock);
    check_output("sat_stall", stall_cycles, 16'hFFFF);
    @(posedge clock); #1;
    set_idle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
